// File: rtl/xor_stream_ctrl.sv
// Job-based streaming XOR engine: consumes paired A/B words, emits A^B with a last
// marker under valid/ready flow control, and signals completion with a done pulse.
module xor_stream_ctrl #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] c_data,
  output logic              c_valid,
  output logic              c_last,
  input  logic              c_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  out_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [LEN_W-1:0]    out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0]   c_data_q, c_data_d;
  logic                c_valid_q, c_valid_d;
  logic                c_last_q, c_last_d;
  logic                accept_s;
  logic                c_fire_s;
  logic                last_word_s;

  // An operand pair is taken only when the output register is free or draining.
  assign accept_s    = (state_q == RUN) && a_valid && b_valid && (!c_valid_q || c_ready);
  assign c_fire_s    = c_valid_q && c_ready;
  assign last_word_s = (remaining_q == LEN_ONE);

  // Job FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == LEN_ZERO) state_d = DONE;
          else                 state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_word_s) state_d = FLUSH;
        else                         state_d = RUN;
      end
      FLUSH: begin
        if (c_fire_s && c_last_q) state_d = DONE;
        else                      state_d = FLUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register, word countdown and delivered-word counter
  always_comb begin
    remaining_d = remaining_q;
    out_cnt_d   = out_cnt_q;
    c_data_d    = c_data_q;
    c_valid_d   = c_valid_q;
    c_last_d    = c_last_q;

    if (accept_s) begin
      c_data_d    = a_data ^ b_data;
      c_valid_d   = 1'b1;
      c_last_d    = last_word_s;
      remaining_d = remaining_q - LEN_ONE;
    end else if (c_fire_s) begin
      c_valid_d = 1'b0;
      c_last_d  = 1'b0;
    end else begin
      c_valid_d = c_valid_q;
    end

    if ((state_q == IDLE) && start) begin
      remaining_d = len;
      out_cnt_d   = LEN_ZERO;
    end else if (c_fire_s && (out_cnt_q != CNT_MAX)) begin
      out_cnt_d = out_cnt_q + LEN_ONE;
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= LEN_ZERO;
      out_cnt_q   <= LEN_ZERO;
      c_data_q    <= {DATA_W{1'b0}};
      c_valid_q   <= 1'b0;
      c_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_cnt_q   <= out_cnt_d;
      c_data_q    <= c_data_d;
      c_valid_q   <= c_valid_d;
      c_last_q    <= c_last_d;
    end
  end

  assign a_ready = accept_s;
  assign b_ready = accept_s;
  assign c_data  = c_data_q;
  assign c_valid = c_valid_q;
  assign c_last  = c_last_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_xor_stream_ctrl.sv
// Self-checking bench for xor_stream_ctrl: table of jobs plus hand-written
// zero-length and mid-job reset sequences, with a result scoreboard.
module tb_xor_stream_ctrl;

  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [LW-1:0] len;
  logic [DW-1:0] a_data, b_data, c_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic          c_valid, c_last, c_ready;
  logic          busy, done;
  logic [LW-1:0] out_cnt;

  always #5 clk = ~clk;

  xor_stream_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .c_data(c_data), .c_valid(c_valid), .c_last(c_last), .c_ready(c_ready),
    .busy(busy), .done(done), .out_cnt(out_cnt)
  );

  typedef struct {
    int          len;
    bit          a_tog;
    bit          b_tog;
    logic [31:0] cr_pat;
    bit          restart;
    bit          fixed;
    int          exp_words;
    int          exp_gap;
  } job_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  job_t jobs[6];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_len = 0, acc_idx = 0, out_words = 0, done_seen = 0;
  int cyc = 0, last_acc_cyc = -1, done_cyc = -1;
  bit job_active = 1'b0;
  bit prev_hold = 1'b0, prev_acc = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at negedge, then advance past the posedge.
  task automatic cycle();
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    if (prev_hold) begin
      check("hold_valid", c_valid, 1);
      check("hold_data", c_data, prev_data);
      check("hold_last", c_last, prev_last);
    end
    if (prev_acc) check("latency_c_valid", c_valid, 1);
    exp_rdy = job_active && (acc_idx < cur_len) && a_valid && b_valid && (!c_valid || c_ready);
    check("a_ready", a_ready, exp_rdy);
    check("b_ready", b_ready, exp_rdy);
    if (job_active) check("busy_active", busy, 1);
    prev_acc = 1'b0;
    if (a_ready === 1'b1) begin
      e.data = a_data ^ b_data;
      e.last = (acc_idx == cur_len - 1);
      sb.push_back(e);
      acc_idx++;
      last_acc_cyc = cyc;
      prev_acc = 1'b1;
    end
    if (c_valid === 1'b1 && c_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_c_valid", c_valid, 0);
      end else begin
        e = sb.pop_front();
        check("c_data", c_data, e.data);
        check("c_last", c_last, e.last);
        out_words++;
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
      job_active = 1'b0;
    end
    prev_hold = (c_valid === 1'b1) && (c_ready === 1'b0);
    prev_data = c_data;
    prev_last = c_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = l[LW-1:0];
    cycle();
    start      = 1'b0;
    cur_len    = l;
    acc_idx    = 0;
    job_active = (l != 0);
  endtask

  task automatic run_job(input job_t j);
    check("idle_busy", busy, 0);
    out_words = 0; done_seen = 0; done_cyc = -1; last_acc_cyc = -1;
    do_start(j.len);
    for (int i = 0; i < 200 && done_seen == 0; i++) begin
      a_valid = (j.a_tog && i[0]) ? 1'b0 : 1'b1;
      b_valid = (j.b_tog && i[1]) ? 1'b0 : 1'b1;
      a_data  = j.fixed ? DW'(acc_idx + 1) : {$urandom, $urandom};
      b_data  = j.fixed ? 64'd3 : {$urandom, $urandom};
      c_ready = (i < 32) ? j.cr_pat[i] : 1'b1;
      start   = j.restart && (i == 1);
      if (start) len = 16'd7;
      cycle();
    end
    start = 1'b0;
    check("done_pulses", done_seen, 1);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("out_cnt", out_cnt, j.len);
    check("words_out", out_words, j.exp_words);
    if (j.exp_gap != 0) check("done_gap", done_cyc - last_acc_cyc, j.exp_gap);
    job_active = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{3, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 3, 2};
    jobs[1] = '{4, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 2};
    jobs[2] = '{2, 1'b0, 1'b0, 32'hFFFF_FFC1, 1'b0, 1'b0, 2, 0};
    jobs[3] = '{2, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, 2};
    jobs[4] = '{6, 1'b1, 1'b1, 32'hA5A5_5AD3, 1'b0, 1'b0, 6, 0};
    jobs[5] = '{1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 2};

    rst_n = 1'b0; start = 1'b0; len = 16'd0;
    a_data = 64'd0; b_data = 64'd0; a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_c_last", c_last, 0);
    check("rst_c_data", c_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_a_ready", a_ready, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_job(jobs[k]);

    // zero-length job: straight to DONE for one cycle
    a_valid = 1'b1; b_valid = 1'b1; c_ready = 1'b1;
    do_start(0);
    check("len0_busy", busy, 1);
    check("len0_done", done, 1);
    check("len0_c_valid", c_valid, 0);
    check("len0_out_cnt", out_cnt, 0);
    cycle();
    check("len0_busy_after", busy, 0);
    check("len0_done_after", done, 0);

    // reset while a result word is pending
    done_seen = 0; out_words = 0;
    do_start(5);
    a_data = {$urandom, $urandom}; b_data = {$urandom, $urandom};
    cycle();
    a_data = {$urandom, $urandom}; b_data = {$urandom, $urandom};
    cycle();
    c_ready = 1'b0;
    cycle();
    check("pre_rst_c_valid", c_valid, 1);
    check("pre_rst_out_cnt", out_cnt, 1);
    rst_n = 1'b0;
    cycle();
    prev_hold = 1'b0; prev_acc = 1'b0; job_active = 1'b0; sb.delete();
    check("midrst_c_valid", c_valid, 0);
    check("midrst_c_last", c_last, 0);
    check("midrst_c_data", c_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out_cnt", out_cnt, 0);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_no_done", done_seen, 0);
    rst_n = 1'b1;
    run_job(jobs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
